projectile_ctl: RTL

//  Per-frame projectile flight engine for a Cat vs Dog shot. Consumes the 7-bit wind value
//  (0..100, 50 = calm) and a launch vector. Integrates position under gravity and wind, then

---
 rtl/projectile_ctl.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/projectile_ctl.sv
// rtl/projectile_ctl.sv - per-frame projectile flight engine for a Cat vs Dog shot
//
// Purpose: launches a shot on fire, integrates position under gravity and a
// wind acceleration latched at launch once per frame_tick, then reports hit
// or miss with a coincident next_turn pulse that advances the wind sequencer.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   frame_tick          1-cycle pulse per video frame (integration step)
//   fire                1-cycle launch request (honoured in IDLE only)
//   start_x, start_y    launch position, px
//   vx0, vy0            signed launch velocity, subpixel/frame (vy0 < 0 = up)
//   wind                wind strength 0..100, WIND_CALM = no drift
//   target_x, target_y  target box top-left corner, px
//   proj_x, proj_y      clamped integer projectile position, px
//   proj_active         high while a shot is in flight
//   hit, miss           1-cycle outcome pulses
//   next_turn           1-cycle pulse coincident with hit or miss

module projectile_ctl #(
   parameter int FRAC       = 4,
   parameter int SCREEN_W   = 1024,
   parameter int GROUND_Y   = 700,
   parameter int GRAVITY    = 1,
   parameter int WIND_CALM  = 50,
   parameter int WIND_SHIFT = 4,
   parameter int TARGET_W   = 64,
   parameter int TARGET_H   = 64,
   parameter int MAX_FRAMES = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        fire,
   input  logic [10:0] start_x,
   input  logic [10:0] start_y,
   input  logic [11:0] vx0,
   input  logic [11:0] vy0,
   input  logic [6:0]  wind,
   input  logic [10:0] target_x,
   input  logic [10:0] target_y,
   output logic [10:0] proj_x,
   output logic [10:0] proj_y,
   output logic        proj_active,
   output logic        hit,
   output logic        miss,
   output logic        next_turn
);

   // Position: 1 sign + 12 integer + FRAC fraction bits.
   localparam int PW = 13 + FRAC;
   localparam int CW = $clog2(MAX_FRAMES + 1);

   localparam logic signed [11:0]   GRAV12     = 12'(GRAVITY);
   localparam logic signed [PW-1:0] SCREEN_W_S = PW'(SCREEN_W);
   localparam logic signed [PW-1:0] GROUND_Y_S = PW'(GROUND_Y);
   localparam logic signed [PW-1:0] TARGET_W_S = PW'(TARGET_W);
   localparam logic signed [PW-1:0] TARGET_H_S = PW'(TARGET_H);
   localparam logic [CW-1:0]        MAX_CNT    = CW'(MAX_FRAMES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FLIGHT = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t state, state_nx;

   logic signed [PW-1:0] pos_x, pos_y;
   logic signed [11:0]   vx, vy;
   logic [6:0]           wind_lat;
   logic [CW-1:0]        frame_cnt;
   logic                 hit_flag;

   logic launch, integrate;

   // Saturating velocity add: overflow shows up as bit 12 disagreeing with bit 11.
   function automatic logic signed [11:0] sat_vel(input logic signed [11:0] a,
                                                  input logic signed [11:0] b);
      logic signed [12:0] s;
      s = {a[11], a} + {b[11], b};
      if (s[12] != s[11])
         sat_vel = s[12] ? 12'sh800 : 12'sh7FF;
      else
         sat_vel = s[11:0];
   endfunction

   // Saturating position step so a long upward flight cannot wrap to the ground.
   function automatic logic signed [PW-1:0] sat_pos(input logic signed [PW-1:0] p,
                                                    input logic signed [11:0]   v);
      logic signed [PW:0] s;
      s = {p[PW-1], p} + {{(PW-11){v[11]}}, v};
      if (s[PW] != s[PW-1])
         sat_pos = s[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
      else
         sat_pos = s[PW-1:0];
   endfunction

   // Wind acceleration with floor semantics: arithmetic shift of the signed offset.
   logic signed [7:0]  wind_off, wacc;
   logic signed [11:0] wacc12;
   assign wind_off = $signed({1'b0, wind_lat}) - $signed(8'(WIND_CALM));
   assign wacc     = wind_off >>> WIND_SHIFT;
   assign wacc12   = {{4{wacc[7]}}, wacc};

   // Next-frame kinematics: position advances by the velocity held before this frame.
   logic signed [PW-1:0] pos_x_nx, pos_y_nx, x_nx_int, y_nx_int;
   logic signed [11:0]   vx_nx, vy_nx;
   logic [10:0]          proj_x_nx, proj_y_nx;

   assign pos_x_nx = sat_pos(pos_x, vx);
   assign pos_y_nx = sat_pos(pos_y, vy);
   assign vx_nx    = sat_vel(vx, wacc12);
   assign vy_nx    = sat_vel(vy, GRAV12);
   assign x_nx_int = pos_x_nx >>> FRAC;
   assign y_nx_int = pos_y_nx >>> FRAC;

   // Display clamp; a shot above the screen keeps flying but draws at row 0.
   always_comb begin
      proj_x_nx = '0;
      proj_y_nx = '0;
      if (x_nx_int[PW-1])
         proj_x_nx = '0;
      else if (x_nx_int >= SCREEN_W_S)
         proj_x_nx = 11'(SCREEN_W - 1);
      else
         proj_x_nx = x_nx_int[10:0];
      if (y_nx_int[PW-1])
         proj_y_nx = '0;
      else if (y_nx_int > GROUND_Y_S)
         proj_y_nx = 11'(GROUND_Y);
      else
         proj_y_nx = y_nx_int[10:0];
   end

   // Outcome evaluation on the registered (post-step) position.
   logic signed [PW-1:0] x_int, y_int, tx_lo, tx_hi, ty_lo, ty_hi;
   logic                 hit_cond, miss_cond;

   assign x_int = pos_x >>> FRAC;
   assign y_int = pos_y >>> FRAC;
   assign tx_lo = $signed({{(PW-11){1'b0}}, target_x});
   assign ty_lo = $signed({{(PW-11){1'b0}}, target_y});
   assign tx_hi = tx_lo + TARGET_W_S;
   assign ty_hi = ty_lo + TARGET_H_S;

   assign hit_cond  = (x_int >= tx_lo) && (x_int < tx_hi) &&
                      (y_int >= ty_lo) && (y_int < ty_hi);
   assign miss_cond = (y_int >= GROUND_Y_S) || pos_x[PW-1] ||
                      (x_int >= SCREEN_W_S) || (frame_cnt == MAX_CNT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      launch      = 1'b0;
      integrate   = 1'b0;
      proj_active = 1'b0;
      hit         = 1'b0;
      miss        = 1'b0;
      next_turn   = 1'b0;
      case (state)
         IDLE: begin
            if (fire) begin
               launch   = 1'b1;
               state_nx = FLIGHT;
            end
         end
         FLIGHT: begin
            proj_active = 1'b1;
            if (frame_tick) begin
               integrate = 1'b1;
               state_nx  = CHECK;
            end
         end
         CHECK: begin
            proj_active = 1'b1;
            if (hit_cond || miss_cond)
               state_nx = DONE;
            else
               state_nx = FLIGHT;
         end
         DONE: begin
            hit       = hit_flag;
            miss      = ~hit_flag;
            next_turn = 1'b1;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos_x     <= '0;
         pos_y     <= '0;
         vx        <= '0;
         vy        <= '0;
         wind_lat  <= '0;
         frame_cnt <= '0;
         hit_flag  <= 1'b0;
         proj_x    <= '0;
         proj_y    <= '0;
      end else begin
         if (launch) begin
            pos_x     <= {{(PW-11-FRAC){1'b0}}, start_x, {FRAC{1'b0}}};
            pos_y     <= {{(PW-11-FRAC){1'b0}}, start_y, {FRAC{1'b0}}};
            vx        <= vx0;
            vy        <= vy0;
            wind_lat  <= wind;
            frame_cnt <= '0;
         end
         if (integrate) begin
            pos_x     <= pos_x_nx;
            pos_y     <= pos_y_nx;
            vx        <= vx_nx;
            vy        <= vy_nx;
            frame_cnt <= frame_cnt + CW'(1);
            proj_x    <= proj_x_nx;
            proj_y    <= proj_y_nx;
         end
         // Hit has priority over miss; remembered for the DONE pulse.
         if (state == CHECK)
            hit_flag <= hit_cond;
      end
   end

endmodule
